// File: rtl/reg_delay_line.sv
// reg_delay_line: runtime-programmable, clock-enabled delay line (0..DEPTH-1
// samples) with fill tracking and an output-valid flag.
// Optional build macro: DELAY_LINE_ZEROFILL_EN forces Q to 0 while the output
// is not yet valid, so stale or uninitialised storage never reaches Q.
module reg_delay_line #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          clr,
    input  logic [AW-1:0] dly,
    input  logic [W-1:0]  D,
    output logic [W-1:0]  Q,
    output logic          q_vld
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = AW + 1;
    localparam logic [AW-1:0] DMAX    = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CMAX    = CW'(DEPTH);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] dly_r;
    logic [CW-1:0] cnt;

    logic [AW-1:0] d_eff;
    logic [AW-1:0] wp_next;
    logic [AW-1:0] rd_idx;
    logic [W-1:0]  rd_data;
    logic [CW-1:0] cnt_next;
    logic          vld_next;
    logic [W-1:0]  q_next;

    // Clamp the delay, compute the read slot, fill count and next output.
    always_comb begin
        d_eff    = (dly > DMAX) ? DMAX : dly;
        wp_next  = (wp == DMAX) ? '0 : wp + AW'(1);
        rd_idx   = '0;
        cnt_next = cnt;
        vld_next = 1'b0;
        q_next   = '0;

        // Circular subtraction without relying on a power-of-two depth.
        if (wp >= d_eff) begin
            rd_idx = wp - d_eff;
        end else begin
            rd_idx = AW'({1'b0, wp} + DEPTH_P - {1'b0, d_eff});
        end
        rd_data = mem[rd_idx];

        // A changed delay invalidates everything already buffered.
        if (d_eff != dly_r) begin
            cnt_next = CW'(1);
        end else if (cnt == CMAX) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CW'(1);
        end

        vld_next = (cnt_next > CW'(d_eff));
        q_next   = (d_eff == '0) ? D : rd_data;
`ifdef DELAY_LINE_ZEROFILL_EN
        if (!vld_next) begin
            q_next = '0;
        end
`else
`endif
    end

    // Sample storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (ce && !clr) begin
            mem[wp] <= D;
        end
    end

    // Control state and registered outputs; clr flushes but keeps dly_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q     <= '0;
            q_vld <= 1'b0;
            wp    <= '0;
            cnt   <= '0;
            dly_r <= '0;
        end else if (clr) begin
            Q     <= '0;
            q_vld <= 1'b0;
            wp    <= '0;
            cnt   <= '0;
        end else if (ce) begin
            Q     <= q_next;
            q_vld <= vld_next;
            wp    <= wp_next;
            cnt   <= cnt_next;
            dly_r <= d_eff;
        end
    end

endmodule

// File: tb/tb_reg_delay_line.sv
// tb_reg_delay_line: directed stimulus against two instances (DEPTH=32 and
// DEPTH=24) sharing inputs; a history-based reference model pushes expected
// outputs into a scoreboard that is drained after every clock edge.
module tb_reg_delay_line;

    localparam int unsigned W  = 16;
    localparam int unsigned DA = 32;
    localparam int unsigned DB = 24;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          clr;
    logic [AW-1:0] dly;
    logic [W-1:0]  D;
    logic [W-1:0]  q_a, q_b;
    logic          vld_a, vld_b;

    always #5 clk = ~clk;

    reg_delay_line #(.W(W), .DEPTH(DA)) u_a (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr), .dly(dly), .D(D),
        .Q(q_a), .q_vld(vld_a)
    );

    reg_delay_line #(.W(W), .DEPTH(DB)) u_b (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr), .dly(dly), .D(D),
        .Q(q_b), .q_vld(vld_b)
    );

    typedef struct {
        int          inst;
        logic [W-1:0] q;
        logic        vld;
        bit          chkq;
        string       tag;
    } exp_t;

    exp_t         sb[$];
    int           ncomp = 0;
    int           nfail = 0;
    bit           zf;

    // Reference model: full history of accepted samples plus per-instance
    // count of samples accepted since the last restart.
    logic [W-1:0] hist[$];
    int           depth[2];
    int           mdly[2];
    int           seg[2];
    logic [W-1:0] lq[2];
    logic         lv[2];
    bit           lk[2];

    task automatic model_reset(input bit keep_dly);
        for (int i = 0; i < 2; i++) begin
            seg[i] = 0;
            lq[i]  = '0;
            lv[i]  = 1'b0;
            lk[i]  = 1'b1;
            if (!keep_dly) mdly[i] = 0;
        end
    endtask

    task automatic push_expect(input string tag);
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            e.inst = i; e.q = lq[i]; e.vld = lv[i]; e.chkq = lk[i]; e.tag = tag;
            sb.push_back(e);
        end
    endtask

    task automatic check_all();
        while (sb.size() > 0) begin
            exp_t         e;
            logic [W-1:0] oq;
            logic         ov;
            e  = sb.pop_front();
            oq = (e.inst == 0) ? q_a : q_b;
            ov = (e.inst == 0) ? vld_a : vld_b;
            ncomp++;
            assert (ov === e.vld) else begin
                nfail++;
                $error("FAIL %s[%0d] q_vld: observed %b expected %b", e.tag, e.inst, ov, e.vld);
            end
            if (e.chkq) begin
                ncomp++;
                assert (oq === e.q) else begin
                    nfail++;
                    $error("FAIL %s[%0d] Q: observed %h expected %h", e.tag, e.inst, oq, e.q);
                end
            end
        end
    endtask

    // One clock of stimulus: drive at negedge, predict, compare after posedge.
    task automatic drive(input bit c, input bit cl, input int dv,
                         input logic [W-1:0] dd, input string tag);
        @(negedge clk);
        ce = c; clr = cl; dly = AW'(dv); D = dd;
        if (cl) begin
            model_reset(1'b1);
        end else if (c) begin
            hist.push_back(dd);
            for (int i = 0; i < 2; i++) begin
                int de;
                de = (dv > depth[i] - 1) ? depth[i] - 1 : dv;
                if (de != mdly[i]) begin
                    mdly[i] = de;
                    seg[i]  = 0;
                end
                seg[i]++;
                lv[i] = (seg[i] >= de + 1);
                if (lv[i]) begin
                    lq[i] = hist[hist.size() - 1 - de];
                    lk[i] = 1'b1;
                end else if (zf) begin
                    lq[i] = '0;
                    lk[i] = 1'b1;
                end else begin
                    lk[i] = 1'b0;
                end
            end
        end
        push_expect(tag);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
`ifdef DELAY_LINE_ZEROFILL_EN
        zf = 1'b1;
`else
        zf = 1'b0;
`endif
        depth[0] = DA;
        depth[1] = DB;
        rst = 1'b1; ce = 1'b0; clr = 1'b0; dly = '0; D = '0;
        model_reset(1'b0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        push_expect("reset");
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Zero delay behaves like a plain enabled register.
        for (int k = 1; k <= 8; k++) drive(1'b1, 1'b0, 0, W'(k), "dly0");

        // Delay of 5: valid at the 6th edge with the first sample.
        for (int k = 0; k < 12; k++) drive(1'b1, 1'b0, 5, W'(100 + k), "dly5");

        // Delay counts accepted samples, not clocks; dly ignored while ce=0.
        for (int k = 0; k < 16; k++)
            drive(k % 2 == 0, 1'b0, (k % 2 == 0) ? 3 : 9, W'(200 + k), "ce_toggle");

        // Delay change mid-stream at edge 20.
        for (int k = 1; k <= 35; k++)
            drive(1'b1, 1'b0, (k < 20) ? 2 : 7, W'(300 + k), "switch");

        // Maximum delay over several wraps; DEPTH=24 instance clamps 31 to 23.
        for (int k = 0; k < 3 * DA; k++) drive(1'b1, 1'b0, 31, W'(1000 + k), "wrap");

        // Synchronous flush with ce=1, then refill.
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 4, W'(2000 + k), "pre_clr");
        drive(1'b1, 1'b1, 4, W'(16'hdead), "clr");
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 4, W'(2100 + k), "refill");

        // Flush coinciding with a delay change: change seen at the next ce edge.
        drive(1'b1, 1'b1, 6, W'(16'hbeef), "clr_dly");
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, 6, W'(2200 + k), "post_clr_dly");

        // Asynchronous reset between edges clears outputs immediately.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset(1'b0);
        push_expect("async_rst");
        check_all();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b0, 3, W'(3000 + k), "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
